// File: rtl/spi_dac_streamer.sv
// spi_dac_streamer: paced SPI streamer for MCP49x1/49x2-class DACs.
// A sample trigger (internal tick or external start) captures all channels,
// shifts one 16-bit command word per channel, then pulses LDAC once.

module spi_dac_streamer #(
  parameter int   DATA_W   = 10,
  parameter int   NCH      = 1,
  parameter int   SCK_DIV  = 25,
  parameter int   TICK_DIV = 5000,
  parameter logic CFG_BUF  = 1'b0,
  parameter logic CFG_GA_N = 1'b1
) (
  input  logic                  i_sysclk,
  input  logic                  i_rst_n,
  input  logic                  i_tick_en,
  input  logic                  i_start,
  input  logic                  i_dac_en,
  input  logic [NCH*DATA_W-1:0] i_data_in,
  input  logic                  i_ovr_clr,
  output logic                  o_dac_sdi,
  output logic                  o_dac_cs,
  output logic                  o_dac_sck,
  output logic                  o_dac_ld,
  output logic                  o_busy,
  output logic                  o_tick,
  output logic                  o_overrun
);

  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int TCK_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCK_DIV - 1);
  localparam logic [TCK_W-1:0] TICK_LAST = TCK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP,
    S_LOAD
  } state_t;

  state_t                  r_state;
  logic [DIV_W-1:0]        r_divCnt;
  logic [3:0]              r_bitCnt;
  logic                    r_ch;
  logic [15:0]             r_shift;
  logic [NCH*DATA_W-1:0]   r_data;
  logic                    r_dacEn;
  logic [TCK_W-1:0]        r_tickCnt;

  logic                    w_trig;
  logic                    w_divDone;
  logic [15:0]             w_firstWord;
  logic [15:0]             w_secondWord;

  // Command word: channel select, buffer, gain, shutdown, left-justified sample.
  function automatic logic [15:0] makeWord(input logic chBit, input logic en,
                                           input logic [DATA_W-1:0] sample);
    logic [11:0] field;
    field = 12'(sample) << (12 - DATA_W);
    return {chBit, CFG_BUF, CFG_GA_N, en, field};
  endfunction

  assign o_tick       = (r_tickCnt == TICK_LAST);
  assign w_trig       = o_tick | i_start;
  assign w_divDone    = (r_divCnt == DIV_LAST);
  assign w_firstWord  = makeWord(1'b0, i_dac_en, i_data_in[DATA_W-1:0]);
  assign w_secondWord = makeWord(1'b1, r_dacEn, r_data[NCH*DATA_W-1 -: DATA_W]);

  // Sample-rate counter: wraps every TICK_DIV cycles, parked at zero when disabled.
  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tickCnt <= '0;
    end else if (!i_tick_en || r_tickCnt == TICK_LAST) begin
      r_tickCnt <= '0;
    end else begin
      r_tickCnt <= r_tickCnt + TCK_W'(1);
    end
  end

  // Sticky overrun: a trigger that lands mid-transfer is lost; set beats clear.
  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overrun <= 1'b0;
    end else if (w_trig && r_state != S_IDLE) begin
      o_overrun <= 1'b1;
    end else if (i_ovr_clr) begin
      o_overrun <= 1'b0;
    end
  end

  // Transfer sequencer: SETUP/SHIFT/HOLD/GAP per channel, then one LDAC pulse.
  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_divCnt  <= '0;
      r_bitCnt  <= '0;
      r_ch      <= 1'b0;
      r_shift   <= '0;
      r_data    <= '0;
      r_dacEn   <= 1'b0;
      o_dac_sdi <= 1'b0;
      o_dac_cs  <= 1'b1;
      o_dac_sck <= 1'b0;
      o_dac_ld  <= 1'b1;
      o_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_data    <= i_data_in;
            r_dacEn   <= i_dac_en;
            r_ch      <= 1'b0;
            r_shift   <= w_firstWord;
            o_dac_sdi <= w_firstWord[15];
            o_dac_cs  <= 1'b0;
            o_dac_sck <= 1'b0;
            o_busy    <= 1'b1;
            r_divCnt  <= '0;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_divDone) begin
            r_divCnt <= '0;
            r_bitCnt <= '0;
            r_state  <= S_SHIFT;
          end else begin
            r_divCnt <= r_divCnt + DIV_W'(1);
          end
        end
        S_SHIFT: begin
          if (w_divDone) begin
            r_divCnt <= '0;
            if (!o_dac_sck) begin
              o_dac_sck <= 1'b1;
            end else begin
              o_dac_sck <= 1'b0;
              if (r_bitCnt == 4'd15) begin
                r_state <= S_HOLD;
              end else begin
                r_bitCnt  <= r_bitCnt + 4'd1;
                r_shift   <= {r_shift[14:0], 1'b0};
                o_dac_sdi <= r_shift[14];
              end
            end
          end else begin
            r_divCnt <= r_divCnt + DIV_W'(1);
          end
        end
        S_HOLD: begin
          if (w_divDone) begin
            r_divCnt <= '0;
            o_dac_cs <= 1'b1;
            r_state  <= S_GAP;
          end else begin
            r_divCnt <= r_divCnt + DIV_W'(1);
          end
        end
        S_GAP: begin
          if (w_divDone) begin
            r_divCnt <= '0;
            if (r_ch == 1'(NCH - 1)) begin
              o_dac_ld <= 1'b0;
              r_state  <= S_LOAD;
            end else begin
              r_ch      <= 1'b1;
              r_shift   <= w_secondWord;
              o_dac_sdi <= w_secondWord[15];
              o_dac_cs  <= 1'b0;
              r_state   <= S_SETUP;
            end
          end else begin
            r_divCnt <= r_divCnt + DIV_W'(1);
          end
        end
        S_LOAD: begin
          if (w_divDone) begin
            r_divCnt  <= '0;
            o_dac_ld  <= 1'b1;
            o_dac_sdi <= 1'b0;
            o_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_divCnt <= r_divCnt + DIV_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_dac_streamer.sv
// tb_spi_dac_streamer: two instances (single-channel defaults, and dual-channel
// with a fast tick) driven by directed and random frames; a passive SPI decoder
// rebuilds each word and LDAC/busy timing for comparison with arithmetic expectations.

module tb_spi_dac_streamer;

  logic        clk = 1'b0;
  logic [1:0]  rstN;
  logic [1:0]  tickEn;
  logic [1:0]  start;
  logic [1:0]  dacEn;
  logic [1:0]  ovrClr;
  logic [9:0]  data0;
  logic [19:0] data1;
  logic [1:0]  sdi, cs, sck, ld, busy, tick, ovr;

  int testCount = 0;
  int failCount = 0;

  // Decoder state, written only by the monitor process.
  logic [15:0] shiftIn [2];
  logic [15:0] words [2][128];
  int          bitsArr [2][128];
  int          ldAtWord [2][128];
  int          wordCnt [2];
  int          bitCnt [2];
  int          ldPulses [2];
  int          ldWidth [2];
  int          lastLdWidth [2];
  int          busyLen [2];
  int          lastBusyLen [2];
  logic [1:0]  prevSck = 2'b00;
  logic [1:0]  prevCs = 2'b11;
  logic [1:0]  prevLd = 2'b11;
  logic [1:0]  prevBusy = 2'b00;

  spi_dac_streamer dut0 (
    .i_sysclk(clk), .i_rst_n(rstN[0]), .i_tick_en(tickEn[0]), .i_start(start[0]),
    .i_dac_en(dacEn[0]), .i_data_in(data0), .i_ovr_clr(ovrClr[0]),
    .o_dac_sdi(sdi[0]), .o_dac_cs(cs[0]), .o_dac_sck(sck[0]), .o_dac_ld(ld[0]),
    .o_busy(busy[0]), .o_tick(tick[0]), .o_overrun(ovr[0])
  );

  spi_dac_streamer #(.NCH(2), .TICK_DIV(1000)) dut1 (
    .i_sysclk(clk), .i_rst_n(rstN[1]), .i_tick_en(tickEn[1]), .i_start(start[1]),
    .i_dac_en(dacEn[1]), .i_data_in(data1), .i_ovr_clr(ovrClr[1]),
    .o_dac_sdi(sdi[1]), .o_dac_cs(cs[1]), .o_dac_sck(sck[1]), .o_dac_ld(ld[1]),
    .o_busy(busy[1]), .o_tick(tick[1]), .o_overrun(ovr[1])
  );

  // 100 MHz-equivalent bench clock; absolute rate is irrelevant to the checks.
  always #5 clk = ~clk;

  // SPI decoder: bits on SCK rises while CS low, word closes on CS rise.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cs[d] == 1'b0 && prevCs[d] == 1'b1) bitCnt[d] = 0;
      if (cs[d] == 1'b0 && sck[d] == 1'b1 && prevSck[d] == 1'b0) begin
        shiftIn[d] = {shiftIn[d][14:0], sdi[d]};
        bitCnt[d]++;
      end
      if (cs[d] == 1'b1 && prevCs[d] == 1'b0) begin
        if (wordCnt[d] < 128) begin
          words[d][wordCnt[d]]    = shiftIn[d];
          bitsArr[d][wordCnt[d]]  = bitCnt[d];
          ldAtWord[d][wordCnt[d]] = ldPulses[d];
        end
        wordCnt[d]++;
        bitCnt[d] = 0;
      end
      if (ld[d] == 1'b0) begin
        ldWidth[d]++;
      end else if (prevLd[d] == 1'b0) begin
        ldPulses[d]++;
        lastLdWidth[d] = ldWidth[d];
        ldWidth[d] = 0;
      end
      if (busy[d] == 1'b1) begin
        busyLen[d]++;
      end else if (prevBusy[d] == 1'b1) begin
        lastBusyLen[d] = busyLen[d];
        busyLen[d] = 0;
      end
      prevSck[d]  = sck[d];
      prevCs[d]   = cs[d];
      prevLd[d]   = ld[d];
      prevBusy[d] = busy[d];
    end
  end

  // Absolute time limit so a stuck design can never hang the run.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected command word from the DAC datasheet layout (BUF=0, GA_n=1).
  function automatic logic [15:0] expWord(input int ch, input int en, input int sample);
    return 16'((ch * 32768) + 8192 + (en * 4096) + (sample * 4));
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One triggered frame via start, optionally corrupting inputs mid-SHIFT.
  task automatic applyStimulus(input int d, input logic [19:0] dataVal, input logic en,
                               input bit scramble);
    int nch;
    int base;
    int ldBase;
    int budget;
    int wi;
    nch    = (d == 0) ? 1 : 2;
    base   = wordCnt[d];
    ldBase = ldPulses[d];
    if (d == 0) data0 = dataVal[9:0];
    else        data1 = dataVal;
    dacEn[d] = en;
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
    checkOutput("busyRise", {31'd0, busy[d]}, 1);
    if (scramble) begin
      repeat (200) step();
      if (d == 0) data0 = ~data0;
      else        data1 = ~data1;
      dacEn[d] = ~en;
    end
    budget = 0;
    while (busy[d] == 1'b1 && budget < 4000) begin
      step();
      budget++;
    end
    checkOutput("busyFall", {31'd0, busy[d]}, 0);
    checkOutput("frameCount", wordCnt[d] - base, nch);
    for (int k = 0; k < nch; k++) begin
      wi = (base + k) % 128;
      checkOutput("word", {16'd0, words[d][wi]},
                  {16'd0, expWord(k, int'(en), int'((dataVal >> (10 * k)) & 20'h3FF))});
      checkOutput("bitCount", bitsArr[d][wi], 16);
      checkOutput("ldBeforeGap", ldAtWord[d][wi], ldBase);
    end
    checkOutput("busyLen", lastBusyLen[d], (35 * nch + 1) * 25);
    checkOutput("ldPulses", ldPulses[d] - ldBase, 1);
    checkOutput("ldWidth", lastLdWidth[d], 25);
  endtask

  initial begin
    int base;
    int ldBase;
    int n;
    int quietTicks;
    int tickTimes [3];
    bit pending;
    int tickNo;
    int nextFree;
    int clrAt;
    bit modelOvr;
    bit checkNow;
    bit clr;
    bit dropped;
    logic [9:0] rdata;

    rstN = 2'b00; tickEn = 2'b00; start = 2'b00; dacEn = 2'b00; ovrClr = 2'b00;
    data0 = '0; data1 = '0;
    step();
    checkOutput("resetOut0", {25'd0, cs[0], ld[0], sck[0], sdi[0], busy[0], tick[0], ovr[0]},
                32'b1100000);
    checkOutput("resetOut1", {25'd0, cs[1], ld[1], sck[1], sdi[1], busy[1], tick[1], ovr[1]},
                32'b1100000);
    rstN = 2'b11;
    repeat (3) step();

    // Directed frames from the datasheet examples.
    applyStimulus(0, 20'h3FF, 1'b1, 1'b0);
    applyStimulus(0, 20'h3FF, 1'b0, 1'b0);
    applyStimulus(1, {10'h155, 10'h200}, 1'b1, 1'b0);

    // Random frames on both instances.
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 20'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 2; i++)
      applyStimulus(1, 20'($urandom_range(0, 20'hFFFFF)), 1'($urandom_range(0, 1)), 1'b0);

    // Inputs changed mid-transfer must not alter the word in flight.
    applyStimulus(0, 20'($urandom_range(0, 1023)), 1'b1, 1'b1);
    applyStimulus(1, 20'($urandom_range(0, 20'hFFFFF)), 1'b1, 1'b1);

    // Asynchronous reset in the middle of SHIFT.
    base = wordCnt[0];
    ldBase = ldPulses[0];
    data0 = 10'h2A5;
    dacEn[0] = 1'b1;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (300) step();
    rstN[0] = 1'b0;
    #1;
    checkOutput("rstAbort", {28'd0, cs[0], sck[0], ld[0], busy[0]}, 32'b1010);
    repeat (3) step();
    checkOutput("rstNoLd", ldPulses[0] - ldBase, 0);
    checkOutput("rstPartial", {31'd0, (wordCnt[0] > base) && (bitsArr[0][base % 128] < 16)}, 1);
    rstN[0] = 1'b1;
    step();
    applyStimulus(0, 20'h2A5, 1'b1, 1'b0);

    // Internal tick pacing on the default instance.
    rdata = 10'($urandom_range(0, 1023));
    data0 = rdata;
    dacEn[0] = 1'b1;
    base = wordCnt[0];
    tickEn[0] = 1'b1;
    n = 0;
    pending = 1'b0;
    for (int s = 0; s < 16000; s++) begin
      step();
      if (pending) begin
        checkOutput("tickStart", {31'd0, busy[0]}, 1);
        pending = 1'b0;
        if (n >= 3) break;
      end
      if (tick[0] == 1'b1) begin
        if (n < 3) tickTimes[n] = s;
        n++;
        checkOutput("tickIdle", {31'd0, busy[0]}, 0);
        pending = 1'b1;
      end
    end
    tickEn[0] = 1'b0;
    checkOutput("tickCount", n, 3);
    checkOutput("tickGap1", tickTimes[1] - tickTimes[0], 5000);
    checkOutput("tickGap2", tickTimes[2] - tickTimes[1], 5000);
    for (int s = 0; s < 2000 && busy[0] == 1'b1; s++) step();
    checkOutput("tickBusyFall", {31'd0, busy[0]}, 0);
    checkOutput("tickOverrun", {31'd0, ovr[0]}, 0);
    checkOutput("tickFrames", wordCnt[0] - base, 3);
    checkOutput("tickWord", {16'd0, words[0][(wordCnt[0] + 127) % 128]},
                {16'd0, expWord(0, 1, int'(rdata))});
    quietTicks = 0;
    for (int s = 0; s < 6000; s++) begin
      step();
      if (tick[0] == 1'b1) quietTicks++;
    end
    checkOutput("tickHeld", quietTicks, 0);

    // Overrun on the dual-channel instance: frame outlasts the tick period.
    checkOutput("ovrInit", {31'd0, ovr[1]}, 0);
    dacEn[1] = 1'b1;
    data1 = 20'($urandom_range(0, 20'hFFFFF));
    tickEn[1] = 1'b1;
    tickNo = 0;
    nextFree = 0;
    clrAt = -1;
    modelOvr = 1'b0;
    checkNow = 1'b0;
    for (int s = 0; s < 7000; s++) begin
      step();
      if (checkNow) begin
        checkOutput("ovrState", {31'd0, ovr[1]}, {31'd0, modelOvr});
        checkNow = 1'b0;
        if (tickNo >= 5) break;
      end
      clr = 1'b0;
      dropped = 1'b0;
      if (tick[1] == 1'b1) begin
        tickNo++;
        if (s >= nextFree) nextFree = s + 1776;
        else               dropped = 1'b1;
        if (tickNo == 2) clrAt = s + 500;
        if (tickNo == 4) clr = 1'b1;
      end
      if (s == clrAt) clr = 1'b1;
      ovrClr[1] = clr;
      if (dropped)  modelOvr = 1'b1;
      else if (clr) modelOvr = 1'b0;
      checkNow = (tick[1] == 1'b1) || clr;
    end
    ovrClr[1] = 1'b0;
    tickEn[1] = 1'b0;
    checkOutput("ovrTicks", tickNo, 5);
    checkOutput("ovrFinal", {31'd0, ovr[1]}, 1);
    for (int s = 0; s < 3000 && busy[1] == 1'b1; s++) step();
    ovrClr[1] = 1'b1;
    step();
    ovrClr[1] = 1'b0;
    step();
    checkOutput("ovrCleared", {31'd0, ovr[1]}, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
